// File: rtl/division_apply_seq_pkg.sv
// Shared types and constants for the element-wise signed divide sequencer.
package division_apply_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RDA,
    RDB,
    LATCH,
    DIV,
    WR,
    DONE
  } state_t;

  localparam int unsigned DIV_CYCLES  = 32;
  localparam logic [31:0] DIV_ZERO_Q  = 32'hFFFF_FFFF;
  localparam int unsigned CMD_ADDR_W  = 8;
  localparam int unsigned CMD_LEN_W   = 8;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] dst;
    logic [CMD_ADDR_W-1:0] src;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/division_apply_seq_if.sv
// Command and EV-store port bundle; slave = sequencer, master = decoder/store side.
interface division_apply_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [LEN_W-1:0]  cmd_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  cmd_valid, cmd_dst, cmd_src, cmd_len, rd_data,
    output cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output cmd_valid, cmd_dst, cmd_src, cmd_len, rd_data,
    input  cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/division_apply_seq_div_iter_s32.sv
// Signed radix-2 restoring divider: one quotient bit per cycle, truncates toward zero.
module div_iter_s32
  import division_apply_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        done
);

  logic        running;
  logic [4:0]  cnt;
  logic        neg;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] work;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_nxt;
  logic [31:0] work_nxt;

  always_comb begin
    trial    = {rem, work[31]};
    diff     = trial - {1'b0, dvs};
    qbit     = ~diff[32];
    rem_nxt  = qbit ? diff[31:0] : trial[31:0];
    work_nxt = {work[30:0], qbit};
  end

  // done is raised during the final iteration so the caller leaves its wait
  // state on the same edge that q takes its signed result.
  assign done = running && (cnt == 5'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      neg     <= 1'b0;
      dvs     <= '0;
      rem     <= '0;
      work    <= '0;
      q       <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      neg     <= a[31] ^ b[31];
      dvs     <= b[31] ? -b : b;
      rem     <= '0;
      work    <= a[31] ? -a : a;
    end else if (running) begin
      rem  <= rem_nxt;
      work <= work_nxt;
      cnt  <= cnt + 5'd1;
      if (done) begin
        running <= 1'b0;
        q       <= neg ? -work_nxt : work_nxt;
      end
    end
  end

endmodule

// File: rtl/division_apply_seq.sv
// Sequencer for dst[i] = dst[i] / src[i] over the EV store, sharing one iterative divider.
// Optional abort/aborted ports enabled by defining DIVAPPLY_ABORT_EN.
module division_apply_seq
  import division_apply_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned LEN_W  = CMD_LEN_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  division_apply_seq_if.slave bus,
  output logic busy,
  output logic done,
  output logic dz_flag
`ifdef DIVAPPLY_ABORT_EN
  ,
  input  logic abort,
  output logic aborted
`endif
);

  state_t            state;
  state_t            state_nxt;
  cmd_t              cmd;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_inc;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       dividend;
  logic [31:0]       div_q;
  logic              zero_div;
  logic              divisor_zero;
  logic              accept;
  logic              abort_hit;
  logic              div_start;
  logic              div_done;

  assign len          = LEN_W'(cmd.len);
  assign idx_a        = ADDR_W'(idx);
  assign dst_addr     = ADDR_W'(cmd.dst) + idx_a;
  assign src_addr     = ADDR_W'(cmd.src) + idx_a;
  assign idx_inc      = idx + LEN_W'(1);
  assign divisor_zero = (bus.rd_data == '0);
  assign accept       = bus.cmd_valid && (state == IDLE);

`ifdef DIVAPPLY_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  div_iter_s32 u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (dividend),
    .b     (bus.rd_data),
    .q     (div_q),
    .done  (div_done)
  );

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    busy          = (state != IDLE);
    done          = 1'b0;
    div_start     = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept) state_nxt = (bus.cmd_len == '0) ? DONE : RDA;
      end
      RDA: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = dst_addr;
        state_nxt   = RDB;
      end
      RDB: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = src_addr;
        state_nxt   = LATCH;
      end
      LATCH: begin
        if (divisor_zero) begin
          state_nxt = WR;
        end else begin
          div_start = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (div_done) state_nxt = WR;
      end
      WR: begin
        if (!abort_hit) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = dst_addr;
          bus.wr_data = DATA_W'(zero_div ? DIV_ZERO_Q : div_q);
        end
        state_nxt = (idx_inc == len) ? DONE : RDA;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      idx      <= '0;
      dividend <= '0;
      zero_div <= 1'b0;
      dz_flag  <= 1'b0;
`ifdef DIVAPPLY_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd <= '{dst: CMD_ADDR_W'(bus.cmd_dst),
                     src: CMD_ADDR_W'(bus.cmd_src),
                     len: CMD_LEN_W'(bus.cmd_len)};
            idx     <= '0;
            dz_flag <= 1'b0;
`ifdef DIVAPPLY_ABORT_EN
            aborted <= 1'b0;
`endif
          end
        end
        RDB:   dividend <= bus.rd_data;
        LATCH: begin
          zero_div <= divisor_zero;
          if (divisor_zero) dz_flag <= 1'b1;
        end
        WR:    idx <= idx_inc;
        default: ;
      endcase
`ifdef DIVAPPLY_ABORT_EN
      if (abort_hit) aborted <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_division_apply_seq.sv
// Directed bench for division_apply_seq with a registered-read EV store model.
module tb_division_apply_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, dz_flag;
`ifdef DIVAPPLY_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:255];

  int vectors = 0;
  int miscompares = 0;
  int overlap_total = 0;

  always #5 clk = ~clk;

  division_apply_seq_if #(.ADDR_W(8), .LEN_W(8), .DATA_W(32)) bus ();

  division_apply_seq #(.ADDR_W(8), .LEN_W(8), .DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .dz_flag (dz_flag)
`ifdef DIVAPPLY_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                         output int dcyc, output int nrd, output int nwr, output logic [31:0] lastw);
    int n;
    dcyc = -1; nrd = 0; nwr = 0; lastw = '0; n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dst = d; bus.cmd_src = s; bus.cmd_len = l;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    while (dcyc < 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.rd_en) nrd++;
      if (bus.wr_en) begin nwr++; lastw = bus.wr_data; end
      if (bus.rd_en && bus.wr_en) overlap_total++;
      if (done) dcyc = n;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({busy, done, dz_flag, bus.cmd_ready, bus.rd_en, bus.wr_en} !== 6'b000100) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 000100", {busy, done, dz_flag, bus.cmd_ready, bus.rd_en, bus.wr_en}); end
    vectors++; if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== 48'h0) begin
      miscompares++; $display("FAIL reset_bus: got %h expected 0", {bus.rd_addr, bus.wr_addr, bus.wr_data}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int d, r, w; logic [31:0] lw;
    poke(8'd0, 32'd10); poke(8'd1, 32'd11); poke(8'd2, 32'd12); poke(8'd3, 32'd13);
    run_cmd(8'd0, 8'd0, 8'd2, d, r, w, lw);
    vectors++; if (d !== 73) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 73", d); end
    vectors++; if (mem[0] !== 32'd1) begin miscompares++; $display("FAIL basic_q0: got %h expected 1", mem[0]); end
    vectors++; if (mem[1] !== 32'd1) begin miscompares++; $display("FAIL basic_q1: got %h expected 1", mem[1]); end
    vectors++; if ({mem[2], mem[3]} !== {32'd12, 32'd13}) begin
      miscompares++; $display("FAIL basic_untouched: got %h expected 0000000c0000000d", {mem[2], mem[3]}); end
    vectors++; if (dz_flag !== 1'b0) begin miscompares++; $display("FAIL basic_dz: got %b expected 0", dz_flag); end
    vectors++; if ({r, w} !== {32'd4, 32'd2}) begin miscompares++; $display("FAIL basic_strobes: rd %0d wr %0d expected 4 2", r, w); end
  endtask

  task automatic test_signed;
    int dv [8] = '{-67, -15, -24, 47, 26, 186, -255, 34567};
    int sv [8] = '{10, -35, 24, -47, 70, 57, -375, 357};
    int qv [8] = '{-6, 0, -1, -1, 0, 3, 0, 96};
    int d, r, w; logic [31:0] lw;
    for (int i = 0; i < 8; i++) begin poke(8'(i), dv[i]); poke(8'(16 + i), sv[i]); end
    poke(8'd8, 32'h5A5A_0008);
    run_cmd(8'd0, 8'd16, 8'd8, d, r, w, lw);
    vectors++; if (d !== 289) begin miscompares++; $display("FAIL signed_done_cycle: got %0d expected 289", d); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (mem[i] !== qv[i]) begin
        miscompares++; $display("FAIL signed_q%0d: got %h expected %h", i, mem[i], qv[i]); end
    end
    vectors++; if ({mem[16], mem[23], mem[8]} !== {32'd10, 32'd357, 32'h5A5A_0008}) begin
      miscompares++; $display("FAIL signed_untouched: got %h", {mem[16], mem[23], mem[8]}); end
  endtask

  task automatic test_div_zero;
    int d, r, w; logic [31:0] lw;
    poke(8'd32, 32'd100); poke(8'd33, 32'd7); poke(8'd34, -32'sd9);
    poke(8'd40, 32'd5);   poke(8'd41, 32'd0); poke(8'd42, 32'd2);
    run_cmd(8'd32, 8'd40, 8'd3, d, r, w, lw);
    vectors++; if (d !== 77) begin miscompares++; $display("FAIL dz_done_cycle: got %0d expected 77", d); end
    vectors++; if ({mem[32], mem[33], mem[34]} !== {32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFC}) begin
      miscompares++; $display("FAIL dz_quotients: got %h expected 00000014fffffffffffffffc", {mem[32], mem[33], mem[34]}); end
    vectors++; if (dz_flag !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", dz_flag); end
  endtask

  task automatic test_len_zero;
    int d, r, w; logic [31:0] lw;
    run_cmd(8'd5, 8'd6, 8'd0, d, r, w, lw);
    vectors++; if (d !== 1) begin miscompares++; $display("FAIL len0_done_cycle: got %0d expected 1", d); end
    vectors++; if ({r, w} !== 64'd0) begin miscompares++; $display("FAIL len0_strobes: rd %0d wr %0d expected 0 0", r, w); end
    vectors++; if (dz_flag !== 1'b0) begin miscompares++; $display("FAIL len0_dz_cleared: got %b expected 0", dz_flag); end
  endtask

  task automatic test_back_to_back;
    int n, d1, d2, early;
    poke(8'd48, 32'd50); poke(8'd49, 32'd5);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dst = 8'd48; bus.cmd_src = 8'd49; bus.cmd_len = 8'd1;
    @(posedge clk);
    n = 0; d1 = -1; early = 0;
    while (d1 < 0 && n < 200) begin
      @(negedge clk); n++;
      if (bus.cmd_ready) early++;
      if (done) d1 = n;
    end
    vectors++; if (d1 !== 37) begin miscompares++; $display("FAIL b2b_first_done: got %0d expected 37", d1); end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL b2b_ready_while_busy: got %0d expected 0", early); end
    @(negedge clk);
    vectors++; if ({busy, bus.cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL b2b_idle_gap: got %b expected 01", {busy, bus.cmd_ready}); end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0; d2 = -1;
    while (d2 < 0 && n < 200) begin
      @(negedge clk); n++;
      if (done) d2 = n;
    end
    vectors++; if (d2 !== 37) begin miscompares++; $display("FAIL b2b_second_done: got %0d expected 37", d2); end
    vectors++; if (mem[48] !== 32'd2) begin miscompares++; $display("FAIL b2b_result: got %h expected 2", mem[48]); end
  endtask

  task automatic test_wrap;
    int d, r, w; logic [31:0] lw;
    poke(8'd255, -32'sd100); poke(8'd0, 32'd1000); poke(8'd1, 32'd77);
    poke(8'd100, 32'd7);     poke(8'd101, -32'sd3);
    run_cmd(8'd255, 8'd100, 8'd2, d, r, w, lw);
    vectors++; if (d !== 73) begin miscompares++; $display("FAIL wrap_done_cycle: got %0d expected 73", d); end
    vectors++; if ({mem[255], mem[0], mem[1]} !== {32'hFFFF_FFF2, 32'hFFFF_FEB3, 32'd77}) begin
      miscompares++; $display("FAIL wrap_results: got %h expected fffffff2fffffeb30000004d", {mem[255], mem[0], mem[1]}); end
  endtask

  task automatic test_min_neg1;
    int d, r, w; logic [31:0] lw;
    poke(8'd60, 32'h8000_0000); poke(8'd61, 32'hFFFF_FFFF);
    run_cmd(8'd60, 8'd61, 8'd1, d, r, w, lw);
    vectors++; if ({w, lw} !== {32'd1, 32'h8000_0000}) begin
      miscompares++; $display("FAIL minneg1_write: count %0d data %h expected 1 80000000", w, lw); end
    vectors++; if ({d, 31'd0, dz_flag} !== {32'd37, 32'd0}) begin
      miscompares++; $display("FAIL minneg1_timing_dz: done %0d dz %b expected 37 0", d, dz_flag); end
  endtask

  task automatic test_reset_mid;
    int n, wr, bad;
    for (int i = 0; i < 3; i++) begin poke(8'(70 + i), 32'd9); poke(8'(80 + i), 32'd3); end
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dst = 8'd70; bus.cmd_src = 8'd80; bus.cmd_len = 8'd3;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0; wr = 0; bad = 0;
    while (n < 50) begin @(negedge clk); n++; if (bus.wr_en) wr++; end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({busy, done, dz_flag, bus.cmd_ready, bus.rd_en, bus.wr_en} !== 6'b000100) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b expected 000100", {busy, done, dz_flag, bus.cmd_ready, bus.rd_en, bus.wr_en}); end
    vectors++; if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== 48'h0) begin
      miscompares++; $display("FAIL rstmid_bus: got %h expected 0", {bus.rd_addr, bus.wr_addr, bus.wr_data}); end
    rst = 1'b0;
    repeat (80) begin @(negedge clk); if (bus.wr_en || done) bad++; end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstmid_quiet: got %0d expected 0", bad); end
    vectors++; if ({wr, mem[70], mem[71]} !== {32'd1, 32'd3, 32'd9}) begin
      miscompares++; $display("FAIL rstmid_mem: wr %0d mem70 %h mem71 %h expected 1 3 9", wr, mem[70], mem[71]); end
  endtask

`ifdef DIVAPPLY_ABORT_EN
  task automatic test_abort;
    int n;
    for (int i = 0; i < 3; i++) begin poke(8'(90 + i), 32'd9); poke(8'(110 + i), 32'd3); end
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dst = 8'd90; bus.cmd_src = 8'd110; bus.cmd_len = 8'd3;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    while (n < 50) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    vectors++; if ({done, aborted, bus.wr_en} !== 3'b110) begin
      miscompares++; $display("FAIL abort_done: got %b expected 110", {done, aborted, bus.wr_en}); end
    abort = 1'b0;
    repeat (40) @(negedge clk);
    vectors++; if ({busy, mem[90], mem[91]} !== {1'b0, 32'd3, 32'd9}) begin
      miscompares++; $display("FAIL abort_mem: busy %b mem90 %h mem91 %h expected 0 3 9", busy, mem[90], mem[91]); end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dst   = '0;
    bus.cmd_src   = '0;
    bus.cmd_len   = '0;
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_len_zero();
    test_back_to_back();
    test_wrap();
    test_min_neg1();
    test_reset_mid();
`ifdef DIVAPPLY_ABORT_EN
    test_abort();
`endif
    vectors++; if (overlap_total !== 0) begin
      miscompares++; $display("FAIL rd_wr_overlap: got %0d expected 0", overlap_total); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
